// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch control path.
// The autostop option is selected with the STOPWATCH_AUTOSTOP_EN macro.
package stopwatch_pkg;

  localparam int CLK_HZ = 100_000_000;
  localparam int TIME_W = 16;
  localparam logic [TIME_W-1:0] DEF_MAX_TIME = 16'h5959;
  localparam int DEF_HOLD_CYCLES = 2 * CLK_HZ;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } sw_state_t;

  // The counter chain advances underneath a frozen lap display as well.
  function automatic logic is_counting(input sw_state_t s);
    return (s == RUNNING) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
// History resets to 1 so a button held through reset never yields a press.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level;
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button presses to counter enable/clear, lap capture and display select.
// Define STOPWATCH_AUTOSTOP_EN to pause and flag at_max when the count reaches MAX_TIME.
import stopwatch_pkg::*;

module stopwatch_ctrl #(
  parameter int                 HOLD_CYCLES = stopwatch_pkg::DEF_HOLD_CYCLES,
  parameter int                 TIME_W      = stopwatch_pkg::TIME_W,
  parameter logic [TIME_W-1:0]  MAX_TIME    = stopwatch_pkg::DEF_MAX_TIME
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              btn_start_stop,
  input  logic              btn_lap,
  input  logic              btn_clear,
  input  logic [TIME_W-1:0] time_in,
  output logic              count_en,
  output logic              count_clr,
  output logic [TIME_W-1:0] display_out,
  output logic [1:0]        state,
  output logic              at_max
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  sw_state_t         state_q;
  logic              count_clr_q;
  logic [TIME_W-1:0] lap_reg;
  logic              at_max_q;
  logic [HOLD_W-1:0] hold_cnt;

  logic press_ss, press_lap, press_clr;
  logic p_clr, p_ss, p_lap;
  logic counting, hold_fire, auto_stop;

  btn_edge u_edge_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_start_stop),
    .press (press_ss)
  );

  btn_edge u_edge_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_lap),
    .press (press_lap)
  );

  btn_edge u_edge_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_clear),
    .press (press_clr)
  );

  // One action per cycle: clear beats start/stop beats lap, losers are dropped.
  assign p_clr = press_clr;
  assign p_ss  = press_ss & ~press_clr;
  assign p_lap = press_lap & ~press_clr & ~press_ss;

  assign counting  = is_counting(state_q);
  assign hold_fire = btn_start_stop && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

`ifdef STOPWATCH_AUTOSTOP_EN
  assign auto_stop = tick & counting & (time_in == MAX_TIME);
`else
  assign auto_stop = 1'b0;
`endif

  // Saturating counter so a very long hold fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!btn_start_stop) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_W'(HOLD_CYCLES)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_clr_q <= 1'b0;
      lap_reg     <= '0;
      at_max_q    <= 1'b0;
    end else begin
      count_clr_q <= 1'b0;
      if (hold_fire) begin
        state_q     <= IDLE;
        count_clr_q <= 1'b1;
        at_max_q    <= 1'b0;
      end else if (auto_stop) begin
        state_q  <= PAUSED;
        at_max_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (p_clr) begin
              count_clr_q <= 1'b1;
            end else if (p_ss) begin
              state_q <= RUNNING;
            end
          end
          RUNNING: begin
            if (p_ss) begin
              state_q <= PAUSED;
            end else if (p_lap) begin
              state_q <= LAP;
              lap_reg <= time_in;
            end
          end
          LAP: begin
            if (p_ss) begin
              state_q <= PAUSED;
            end else if (p_lap) begin
              state_q <= RUNNING;
            end
          end
          PAUSED: begin
            if (p_clr) begin
              state_q     <= IDLE;
              count_clr_q <= 1'b1;
              at_max_q    <= 1'b0;
            end else if (p_ss && !at_max_q) begin
              state_q <= RUNNING;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Gate uses the pre-transition state, so a tick coinciding with a press follows the old state.
  assign count_en    = tick & counting & ~auto_stop;
  assign count_clr   = count_clr_q;
  assign display_out = (state_q == LAP) ? lap_reg : time_in;
  assign state       = state_q;
  assign at_max      = at_max_q;

endmodule
